// File: rtl/flght_mix_pipe.sv
// Quad-rotor motor mixer with arming/spin-up FSM, calibration hold, two-sided
// saturation, per-motor slew limiting and a 2-stage RUN pipeline.
module flght_mix_pipe #(
    parameter int SPD_W         = 11,
    parameter int THRST_W       = 9,
    parameter int PTERM_W       = 10,
    parameter int DTERM_W       = 12,
    parameter int MIN_RUN_SPEED = 'h2C0,
    parameter int CAL_SPEED     = 'h290,
    parameter int MIN_CLAMP     = 0,
    parameter int SLEW_MAX      = 'h040,
    parameter int SPINUP_STEP   = 'h010,
    parameter int SPINUP_DIV    = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm,
    input  logic                      inertial_cal,
    input  logic                      vld,
    input  logic [THRST_W-1:0]        thrst,
    input  logic signed [PTERM_W-1:0] ptch_pterm,
    input  logic signed [PTERM_W-1:0] roll_pterm,
    input  logic signed [PTERM_W-1:0] yaw_pterm,
    input  logic signed [DTERM_W-1:0] ptch_dterm,
    input  logic signed [DTERM_W-1:0] roll_dterm,
    input  logic signed [DTERM_W-1:0] yaw_dterm,
    output logic [SPD_W-1:0]          frnt_spd,
    output logic [SPD_W-1:0]          bck_spd,
    output logic [SPD_W-1:0]          lft_spd,
    output logic [SPD_W-1:0]          rght_spd,
    output logic                      spd_vld,
    output logic [1:0]                state
);

    localparam int SW    = SPD_W + 3;
    localparam int CNT_W = (SPINUP_DIV > 1) ? $clog2(SPINUP_DIV) : 1;

    localparam logic [SPD_W-1:0]     RUN_SPD   = SPD_W'(MIN_RUN_SPEED);
    localparam logic [SPD_W-1:0]     CAL_SPD   = SPD_W'(CAL_SPEED);
    localparam logic [SPD_W-1:0]     CLAMP_SPD = SPD_W'(MIN_CLAMP);
    localparam logic [SPD_W-1:0]     SLEW_SPD  = SPD_W'(SLEW_MAX);
    localparam logic [SPD_W:0]       STEP_SPD  = (SPD_W+1)'(SPINUP_STEP);
    localparam logic signed [SW-1:0] RUN_X     = SW'(MIN_RUN_SPEED);
    localparam logic signed [SW-1:0] MIN_X     = SW'(MIN_CLAMP);
    localparam logic signed [SW-1:0] MAX_X     = SW'((1 << SPD_W) - 1);
    localparam logic [CNT_W-1:0]     TICK_LAST = CNT_W'(SPINUP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPINUP = 2'd1,
        RUN    = 2'd2,
        CAL    = 2'd3
    } state_t;

    state_t cur_state, nxt_state;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [SPD_W:0]   ramp_sum;
    logic [SPD_W-1:0] ramp_nxt;
    logic             spin_done;

    logic signed [SW-1:0] thr_x, base_x, ptch_x, roll_x, yaw_x;
    logic signed [SW-1:0] mix_f, mix_b, mix_l, mix_r;
    logic signed [SW-1:0] s1_f, s1_b, s1_l, s1_r;
    logic                 s1_vld;

    logic [SPD_W-1:0] f_nxt, b_nxt, l_nxt, r_nxt;
    logic             spd_pulse;

    function automatic logic [SPD_W-1:0] sat(input logic signed [SW-1:0] s);
        if (s < MIN_X)      return CLAMP_SPD;
        else if (s > MAX_X) return '1;
        else                return s[SPD_W-1:0];
    endfunction

    function automatic logic [SPD_W-1:0] slew(input logic [SPD_W-1:0] prev,
                                              input logic [SPD_W-1:0] tgt);
        if (SLEW_SPD == '0)  return tgt;
        else if (tgt > prev) return ((tgt - prev) > SLEW_SPD) ? prev + SLEW_SPD : tgt;
        else                 return ((prev - tgt) > SLEW_SPD) ? prev - SLEW_SPD : tgt;
    endfunction

    assign state = cur_state;

    // Spin-up ramp: all four motors share one value, so frnt_spd stands for all.
    assign tick      = (cur_state == SPINUP) && (tick_cnt == TICK_LAST);
    assign ramp_sum  = {1'b0, frnt_spd} + STEP_SPD;
    assign ramp_nxt  = (ramp_sum >= {1'b0, RUN_SPD}) ? RUN_SPD : ramp_sum[SPD_W-1:0];
    assign spin_done = tick && (ramp_nxt == RUN_SPD);

    assign thr_x  = $signed({{(SW-THRST_W){1'b0}}, thrst});
    assign base_x = thr_x + RUN_X;
    assign ptch_x = $signed({{(SW-PTERM_W){ptch_pterm[PTERM_W-1]}}, ptch_pterm})
                  + $signed({{(SW-DTERM_W){ptch_dterm[DTERM_W-1]}}, ptch_dterm});
    assign roll_x = $signed({{(SW-PTERM_W){roll_pterm[PTERM_W-1]}}, roll_pterm})
                  + $signed({{(SW-DTERM_W){roll_dterm[DTERM_W-1]}}, roll_dterm});
    assign yaw_x  = $signed({{(SW-PTERM_W){yaw_pterm[PTERM_W-1]}}, yaw_pterm})
                  + $signed({{(SW-DTERM_W){yaw_dterm[DTERM_W-1]}}, yaw_dterm});
    assign mix_f  = base_x - ptch_x - yaw_x;
    assign mix_b  = base_x + ptch_x - yaw_x;
    assign mix_l  = base_x - roll_x + yaw_x;
    assign mix_r  = base_x + roll_x + yaw_x;

    // Disarm beats calibration, which beats every normal transition.
    always_comb begin
        nxt_state = cur_state;
        if (!arm) begin
            nxt_state = IDLE;
        end else if (inertial_cal) begin
            nxt_state = CAL;
        end else begin
            case (cur_state)
                IDLE:    nxt_state = SPINUP;
                SPINUP:  if (spin_done) nxt_state = RUN;
                CAL:     nxt_state = RUN;
                default: nxt_state = cur_state;
            endcase
        end
    end

    // Outputs follow the state being entered, so a pipeline sample in flight
    // when RUN is left simply never reaches the speed registers.
    always_comb begin
        spd_pulse = 1'b0;
        f_nxt     = frnt_spd;
        b_nxt     = bck_spd;
        l_nxt     = lft_spd;
        r_nxt     = rght_spd;
        case (nxt_state)
            IDLE: begin
                f_nxt = '0; b_nxt = '0; l_nxt = '0; r_nxt = '0;
            end
            SPINUP: begin
                if (cur_state != SPINUP) begin
                    f_nxt = '0; b_nxt = '0; l_nxt = '0; r_nxt = '0;
                end else if (tick) begin
                    f_nxt = ramp_nxt; b_nxt = ramp_nxt; l_nxt = ramp_nxt; r_nxt = ramp_nxt;
                    spd_pulse = 1'b1;
                end
            end
            CAL: begin
                if (cur_state != CAL) begin
                    f_nxt = CAL_SPD; b_nxt = CAL_SPD; l_nxt = CAL_SPD; r_nxt = CAL_SPD;
                    spd_pulse = 1'b1;
                end
            end
            RUN: begin
                if (cur_state == SPINUP) begin
                    f_nxt = ramp_nxt; b_nxt = ramp_nxt; l_nxt = ramp_nxt; r_nxt = ramp_nxt;
                    spd_pulse = 1'b1;
                end else if ((cur_state == RUN) && s1_vld) begin
                    f_nxt = slew(frnt_spd, sat(s1_f));
                    b_nxt = slew(bck_spd,  sat(s1_b));
                    l_nxt = slew(lft_spd,  sat(s1_l));
                    r_nxt = slew(rght_spd, sat(s1_r));
                    spd_pulse = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
            tick_cnt  <= '0;
            s1_vld    <= 1'b0;
            s1_f      <= '0;
            s1_b      <= '0;
            s1_l      <= '0;
            s1_r      <= '0;
            frnt_spd  <= '0;
            bck_spd   <= '0;
            lft_spd   <= '0;
            rght_spd  <= '0;
            spd_vld   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            tick_cnt  <= ((cur_state != SPINUP) || tick) ? '0 : tick_cnt + CNT_W'(1);
            s1_vld    <= vld && (cur_state == RUN) && (nxt_state == RUN);
            if (vld && (cur_state == RUN)) begin
                s1_f <= mix_f;
                s1_b <= mix_b;
                s1_l <= mix_l;
                s1_r <= mix_r;
            end
            frnt_spd <= f_nxt;
            bck_spd  <= b_nxt;
            lft_spd  <= l_nxt;
            rght_spd <= r_nxt;
            spd_vld  <= spd_pulse;
        end
    end

endmodule
